// File: rtl/keypad_entry.sv
// Scans a 4x4 keypad, debounces presses and accumulates decimal digits into a 16-bit value.
// key_strobe/load assert the cycle after the sample closing the last matching frame; no backpressure.
module keypad_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int STABLE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] data,
    output logic        load,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic [2:0]  digit_count,
    output logic        overflow
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int CNT_W = $clog2(STABLE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_ACCEPT, S_RELEASE} state_t;

    logic [3:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_acc_n;
    logic [3:0]       r_acc_code;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_cand, w_cand_nxt;
    logic [3:0]       r_key_code;
    logic [15:0]      r_data;
    logic [2:0]       r_dig_cnt;
    logic             r_ovf;

    logic             w_sample, w_frame_end, w_key, w_none, w_accept, w_load;
    logic [3:0]       w_row_low;
    logic [1:0]       w_col_n, w_col_row, w_tot_n;
    logic [2:0]       w_sum;
    logic [3:0]       w_tot_code;
    logic             w_is_digit;
    logic [3:0]       w_digit;
    logic [19:0]      w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample    = (r_div == DIV_LAST);
    assign w_frame_end = w_sample && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
        end else if (w_sample) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_div     <= r_div + DIV_W'(1);
        end
    end

    // Low-bit count per column saturates at 2; that is all MULTI detection needs.
    assign w_row_low = ~r_sync2;
    always_comb begin
        w_col_n   = 2'd0;
        w_col_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_row_low[i]) begin
                if (w_col_n != 2'd2) w_col_n = w_col_n + 2'd1;
                w_col_row = 2'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_acc_n} + {1'b0, w_col_n};
    assign w_tot_n    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_tot_code = (r_acc_n == 2'd0) ? {w_col_row, r_col_idx} : r_acc_code;
    assign w_key      = w_frame_end && (w_tot_n == 2'd1);
    assign w_none     = w_frame_end && (w_tot_n == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_n    <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_sample) begin
            r_acc_n    <= w_frame_end ? 2'd0 : w_tot_n;
            r_acc_code <= w_tot_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        case (r_state)
            S_IDLE: begin
                if (w_key) begin
                    w_cand_nxt  = w_tot_code;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (CNT_DONE == CNT_W'(1)) ? S_ACCEPT : S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (w_frame_end) begin
                    if (w_key && (w_tot_code == r_cand)) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt + CNT_W'(1) == CNT_DONE) w_state_nxt = S_ACCEPT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_ACCEPT: begin
                w_state_nxt = S_RELEASE;
                w_cnt_nxt   = '0;
            end
            default: begin
                if (w_none) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt + CNT_W'(1) == CNT_DONE) w_state_nxt = S_IDLE;
                end else if (w_frame_end) begin
                    w_cnt_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (r_cand)
            4'd0:  w_digit = 4'd1;
            4'd1:  w_digit = 4'd2;
            4'd2:  w_digit = 4'd3;
            4'd4:  w_digit = 4'd4;
            4'd5:  w_digit = 4'd5;
            4'd6:  w_digit = 4'd6;
            4'd8:  w_digit = 4'd7;
            4'd9:  w_digit = 4'd8;
            4'd10: w_digit = 4'd9;
            4'd13: w_digit = 4'd0;
            default: w_is_digit = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_ACCEPT);
    assign w_load   = w_accept && (r_cand == 4'd14) && !r_ovf && (r_dig_cnt != 3'd0);
    assign w_next   = ({4'd0, r_data} << 3) + ({4'd0, r_data} << 1) + {16'd0, w_digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code <= 4'd0;
            r_data     <= 16'd0;
            r_dig_cnt  <= 3'd0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_key_code <= r_cand;
            if (w_is_digit) begin
                if (!r_ovf) begin
                    if (w_next > 20'h0FFFF) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_data    <= w_next[15:0];
                        r_dig_cnt <= r_dig_cnt + 3'd1;
                    end
                end
            end else if ((r_cand == 4'd12) || (r_cand == 4'd14)) begin
                // Enter clears as well: after a load, or instead of one when the entry is unusable.
                r_data    <= 16'd0;
                r_dig_cnt <= 3'd0;
                r_ovf     <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign load        = w_load;
    assign key_strobe  = w_accept;
    assign key_code    = w_accept ? r_cand : r_key_code;
    assign digit_count = r_dig_cnt;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_keypad_entry.sv
// Keypad bench: a key matrix model drives row from col; accepted keys are scoreboarded against a reference accumulator.
module tb_keypad_entry;
    localparam int FRAME = 16;
    localparam int KV[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -2, 0, -3, -1};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] data;
    logic        load, key_strobe, overflow;
    logic [3:0]  key_code;
    logic [2:0]  digit_count;
    logic [15:0] pressed;

    typedef struct {
        int code; int ld; int dat; int dat_after; int cnt_after; int ovf_after;
    } exp_t;
    exp_t sb[$];
    exp_t pend;
    bit   have_after = 1'b0;
    bit   prev_strobe = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_data = 0, m_cnt = 0, m_ovf = 0;

    keypad_entry #(.SCAN_DIV(4), .STABLE_SCANS(2)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .data(data), .load(load),
        .key_strobe(key_strobe), .key_code(key_code), .digit_count(digit_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int code_of(input int d);
        for (int i = 0; i < 16; i++) if (KV[i] == d) return i;
        return 15;
    endfunction

    task automatic model_accept(input int code);
        exp_t e;
        int nx;
        e.code = code; e.ld = 0; e.dat = m_data;
        if (KV[code] >= 0) begin
            nx = m_data * 10 + KV[code];
            if (m_ovf == 0) begin
                if (nx > 65535) m_ovf = 1;
                else begin m_data = nx; m_cnt++; end
            end
        end else if (KV[code] == -2 || KV[code] == -3) begin
            if (KV[code] == -3 && m_ovf == 0 && m_cnt != 0) e.ld = 1;
            m_data = 0; m_cnt = 0; m_ovf = 0;
        end
        e.dat_after = m_data; e.cnt_after = m_cnt; e.ovf_after = m_ovf;
        sb.push_back(e);
    endtask

    task automatic press(input int code, input int hold_fr, input int rel_fr, input bit acc);
        if (acc) model_accept(code);
        @(posedge clk); #1;
        pressed[code] = 1'b1;
        repeat (hold_fr * FRAME) @(posedge clk);
        #1 pressed[code] = 1'b0;
        repeat (rel_fr * FRAME) @(posedge clk);
    endtask

    task automatic digit(input int d);
        press(code_of(d), 4, 3, 1'b1);
    endtask

    always @(negedge clk) begin
        if (have_after) begin
            chk("data_after", data, pend.dat_after);
            chk("count_after", digit_count, pend.cnt_after);
            chk("ovf_after", overflow, pend.ovf_after);
            have_after = 1'b0;
        end
        if (load && !key_strobe) chk("load_without_strobe", 1, 0);
        if (key_strobe) begin
            if (prev_strobe) chk("strobe_width", 2, 1);
            if (sb.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                pend = sb.pop_front();
                chk("key_code", key_code, pend.code);
                chk("load", load, pend.ld);
                chk("data_at_strobe", data, pend.dat);
                have_after = 1'b1;
            end
        end
        prev_strobe = key_strobe;
    end

    initial begin
        bit found;
        logic [3:0] prev_col;
        rst = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", col, 4'b1110);
        chk("rst_data", data, 0);
        chk("rst_strobe", key_strobe, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);

        // 12345 then enter
        for (int d = 1; d <= 5; d++) digit(d);
        digit(-3);

        // 65535 fits, 65536 overflows
        digit(6); digit(5); digit(5); digit(3); digit(5);
        digit(-2);
        digit(6); digit(5); digit(5); digit(3); digit(6);
        digit(-3);

        // debounce: short tap, long hold, early re-press, proper re-press
        press(code_of(7), 1, 4, 1'b0);
        press(code_of(7), 10, 1, 1'b1);
        press(code_of(7), 4, 2, 1'b0);
        press(code_of(7), 4, 3, 1'b1);

        // two keys at once, letter key, enter on empty entry
        digit(-2);
        @(posedge clk); #1;
        pressed[0] = 1'b1; pressed[1] = 1'b1;
        repeat (4 * FRAME) @(posedge clk);
        #1 pressed = '0;
        repeat (3 * FRAME) @(posedge clk);
        digit(7);
        press(3, 4, 3, 1'b1);
        digit(-2);
        digit(-3);

        // reset during debounce of 9
        digit(4); digit(2);
        found = 1'b0;
        prev_col = col;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b1110 && prev_col == 4'b0111) found = 1'b1;
            prev_col = col;
        end
        chk("frame_sync", found, 1);
        pressed[code_of(9)] = 1'b1;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_count", digit_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_load", load, 0);
        chk("mid_rst_strobe", key_strobe, 0);
        chk("mid_rst_code", key_code, 0);
        m_data = 0; m_cnt = 0; m_ovf = 0;
        pressed = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5 * FRAME) @(posedge clk);
        digit(3);

        repeat (2 * FRAME) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Decimal data-entry front end for the calculator datapath: scans a 4x4 matrix keypad, debounces key presses, and accumulates decimal digits into a 16-bit unsigned binary value. It is the input-side counterpart of the binary-to-BCD/7-segment display chain. On the enter key it drives `data` and emits a one-cycle `load` pulse, which the control unit uses to capture operands into the X/Y registers in place of the switch bank.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven. Must be ≥ 4.
- `STABLE_SCANS`, default 4: consecutive identical scan frames required to accept a press, and consecutive empty frames required to re-arm.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high; clears all state immediately.
- `row` in 4: keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one bit low at any time.
- `data` out 16: current accumulated value (unsigned binary).
- `load` out 1: one-cycle pulse; `data` is valid and must be captured in this cycle.
- `key_strobe` out 1: one-cycle pulse per accepted key (any key).
- `key_code` out 4: code of the last accepted key.
- `digit_count` out 3: digits accumulated since the last clear, 0..5.
- `overflow` out 1: sticky; the last digit would have exceeded 65535.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- **Scan**
  - The column index cycles 0→1→2→3→0, advancing every `SCAN_DIV` cycles.
  - `col` = ~(1<<index).
  - The synchronized `row` is sampled in the last cycle of each column period (divider == `SCAN_DIV`-1).
  - 4 column periods make one frame.
- **Key map** (row r, column c; code = 4r+c): 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  - Digits map to values 0..9.
  - `*` = clear, `#` = enter.
  - A, B, C and D are accepted (strobe and `key_code` update) but take no action.
- **Frame result** is one of:
  - NONE: no low row in any column.
  - KEY(code): exactly one low row-bit across the whole frame.
  - MULTI: two or more low bits; treated as NONE for acceptance and as non-empty for re-arm.
- **FSM** (evaluated at each frame end):
  - IDLE: KEY(k) → DEBOUNCE with cand=k, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - KEY(cand) → cnt+1. When cnt reaches `STABLE_SCANS`, go to ACCEPT.
    - Any other result → IDLE.
    - With `STABLE_SCANS`=1, a KEY result goes from IDLE straight to ACCEPT.
  - ACCEPT (1 cycle): `key_strobe`=1, `key_code`=cand, perform the action, → RELEASE with cnt=0.
  - RELEASE:
    - NONE → cnt+1. When cnt reaches `STABLE_SCANS`, go to IDLE.
    - KEY or MULTI → cnt=0.
    - A held key therefore yields exactly one acceptance.
- **Digit d**
  - Compute next = data*10 + d in ≥ 20-bit width as (data<<3)+(data<<1)+d.
  - If `overflow` is already 1: no change.
  - Else if next > 65535: `overflow`←1; `data` and `digit_count` unchanged.
  - Else: `data`←next[15:0], `digit_count`+1.
- **Clear `*`**: `data`←0, `digit_count`←0, `overflow`←0.
- **Enter `#`**
  - If `overflow`=1 or `digit_count`=0: no `load`; perform clear.
  - Else: `load`=1 in the ACCEPT cycle with the current `data`; next cycle `data`←0, `digit_count`←0.

## Timing
- **Reset values**: `col`=4'b1110 (index 0), divider 0, FSM IDLE, `data`=0, `load`=0, `key_strobe`=0, `key_code`=0, `digit_count`=0, `overflow`=0, synchronizer flops 1.
- **Press latency**:
  - Measured from the sample that completes the `STABLE_SCANS`-th matching frame, `key_strobe`/`load` assert the next cycle.
  - `data` and `digit_count` update on the clock edge ending the ACCEPT cycle.
- **Minimum hold for acceptance**: `STABLE_SCANS` full frames (4·`SCAN_DIV`·`STABLE_SCANS` cycles) plus 2 synchronizer cycles.
- `load` and `key_strobe` are never high for more than one consecutive cycle.
- `load` implies `key_strobe`=1 and `key_code`=14 (`#`) in the same cycle.
- A frame boundary coinciding with ACCEPT is not possible: ACCEPT is entered one cycle after the sample, and the next sample is ≥ 4 cycles later.
- Reset asserted mid-debounce or mid-entry forces all outputs to their reset values immediately; no `load` or strobe is generated after release until a full new press is accepted.

## Test plan
Bench parameters: `SCAN_DIV`=4, `STABLE_SCANS`=2; the keypad model drives `row` from `col`.
- **Reset**: assert `rst` asynchronously mid-cycle → `col`=1110, `data`=0, `digit_count`=0, `overflow`=0, and `load`/`key_strobe` low.
- **Normal entry**: press 1,2,3,4,5 then `#` → 5 strobes, then `load`=1 for 1 cycle with `data`=16'h3039 (12345); next cycle `data`=0, `digit_count`=0.
- **Overflow**:
  - Enter 6,5,5,3,5 → `data`=65535.
  - Clear, enter 6,5,5,3,6 → `overflow`=1, `data`=6553, `digit_count`=4.
  - `#` → no `load`, `data`=0, `overflow`=0.
- **Debounce**:
  - Key 7 held 1 frame → no strobe.
  - Held 10 frames → exactly one strobe with `key_code`=8 and `data`=7.
  - Re-press after 1 empty frame → ignored; after 2 empty frames → accepted.
- **Invalid keys**:
  - Keys 1 and 2 held together → no strobe.
  - Key A → strobe, `key_code`=3, `data` unchanged.
  - `#` with `digit_count`=0 → no `load`.
- **Reset mid-entry**: enter 4,2, then pulse `rst` during the debounce of 9 → all cleared and no strobe for 9.
